// File: rtl/trap_recovery_sequencer_if.sv
// rtl/trap_recovery_sequencer_if.sv - port bundle between exception handler, ROB/fetch and the recovery sequencer
interface trap_recovery_sequencer_if #(
  parameter int PTR_W = 4
);
  logic             recover;
  logic [PTR_W-1:0] recover_rob_ptr;
  logic [31:0]      trap_pc;
  logic [31:0]      exception_pc;
  logic [PTR_W-1:0] rob_tail;
  logic             rob_full;
  logic             redirect_ready;
  logic             rob_flush_valid;
  logic [PTR_W-1:0] rob_flush_idx;
  logic             pipe_flush;
  logic             busy;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [31:0]      epc;
  logic             recover_dropped;

  modport master (
    input  recover, recover_rob_ptr, trap_pc, exception_pc, rob_tail, rob_full, redirect_ready,
    output rob_flush_valid, rob_flush_idx, pipe_flush, busy, redirect_valid, redirect_pc, epc,
           recover_dropped
  );

  modport slave (
    output recover, recover_rob_ptr, trap_pc, exception_pc, rob_tail, rob_full, redirect_ready,
    input  rob_flush_valid, rob_flush_idx, pipe_flush, busy, redirect_valid, redirect_pc, epc,
           recover_dropped
  );
endinterface

// File: rtl/trap_recovery_sequencer.sv
// rtl/trap_recovery_sequencer.sv - walks the ROB youngest-first on a trap, drains, then redirects fetch
// All outputs are registered; every flop is loaded from its _d computed in the single combinational block.
module trap_recovery_sequencer #(
  parameter int ROB_DEPTH    = 16,
  parameter int PTR_W        = 4,
  parameter int DRAIN_CYCLES = 2
) (
  input logic                       clk,
  input logic                       reset,
  trap_recovery_sequencer_if.master io
);
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_W'(DRAIN_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_DRAIN,
    S_REDIRECT
  } state_t;

  state_t           state_q, state_d;
  state_t           after_flush;
  logic             recover_q, recover_d;
  logic [PTR_W-1:0] walker_q, walker_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [31:0]      exc_q, exc_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic [31:0]      epc_q, epc_d;
  logic             flush_valid_q, flush_valid_d;
  logic [PTR_W-1:0] flush_idx_q, flush_idx_d;
  logic             busy_q, busy_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic             dropped_q, dropped_d;
  logic             start;
  logic [PTR_W-1:0] span;
  logic [PTR_W:0]   start_cnt;

  always_comb begin
    after_flush      = (DRAIN_CYCLES != 0) ? S_DRAIN : S_REDIRECT;
    start            = io.recover & ~recover_q;
    span             = io.rob_tail - io.recover_rob_ptr;
    start_cnt        = {1'b0, span};
    // tail == ptr is either an empty span or the whole ROB; rob_full decides
    if (span == '0 && io.rob_full) begin
      start_cnt = (PTR_W+1)'(ROB_DEPTH);
    end

    state_d          = state_q;
    recover_d        = io.recover;
    walker_d         = walker_q;
    cnt_d            = cnt_q;
    drain_d          = drain_q;
    exc_d            = exc_q;
    redirect_pc_d    = redirect_pc_q;
    epc_d            = epc_q;
    dropped_d        = start && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          walker_d      = io.rob_tail - PTR_W'(1);
          cnt_d         = start_cnt;
          redirect_pc_d = io.trap_pc;
          exc_d         = io.exception_pc;
          drain_d       = DRAIN_LOAD;
          state_d       = (start_cnt != '0) ? S_FLUSH : after_flush;
        end
      end
      S_FLUSH: begin
        walker_d = walker_q - PTR_W'(1);
        cnt_d    = cnt_q - (PTR_W+1)'(1);
        if (cnt_q == (PTR_W+1)'(1)) begin
          drain_d = DRAIN_LOAD;
          state_d = after_flush;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          state_d = S_REDIRECT;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      S_REDIRECT: begin
        if (io.redirect_ready) begin
          epc_d   = exc_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Moore outputs are computed from the next state so they register alongside it
    busy_d           = (state_d != S_IDLE);
    flush_valid_d    = (state_d == S_FLUSH);
    flush_idx_d      = (state_d == S_FLUSH) ? walker_d : '0;
    redirect_valid_d = (state_d == S_REDIRECT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      recover_q        <= 1'b0;
      walker_q         <= '0;
      cnt_q            <= '0;
      drain_q          <= '0;
      exc_q            <= '0;
      redirect_pc_q    <= '0;
      epc_q            <= '0;
      flush_valid_q    <= 1'b0;
      flush_idx_q      <= '0;
      busy_q           <= 1'b0;
      redirect_valid_q <= 1'b0;
      dropped_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      recover_q        <= recover_d;
      walker_q         <= walker_d;
      cnt_q            <= cnt_d;
      drain_q          <= drain_d;
      exc_q            <= exc_d;
      redirect_pc_q    <= redirect_pc_d;
      epc_q            <= epc_d;
      flush_valid_q    <= flush_valid_d;
      flush_idx_q      <= flush_idx_d;
      busy_q           <= busy_d;
      redirect_valid_q <= redirect_valid_d;
      dropped_q        <= dropped_d;
    end
  end

  assign io.rob_flush_valid = flush_valid_q;
  assign io.rob_flush_idx   = flush_idx_q;
  assign io.pipe_flush      = busy_q;
  assign io.busy            = busy_q;
  assign io.redirect_valid  = redirect_valid_q;
  assign io.redirect_pc     = redirect_pc_q;
  assign io.epc             = epc_q;
  assign io.recover_dropped = dropped_q;
endmodule

// File: tb/tb_trap_recovery_sequencer.sv
// tb/tb_trap_recovery_sequencer.sv - scoreboard bench for trap_recovery_sequencer
module tb_trap_recovery_sequencer;
  localparam int PTR_W = 4;
  localparam int DEPTH = 16;
  localparam int D     = 2;

  typedef struct {
    logic [PTR_W-1:0] idx;
    int               cyc;
  } flush_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] exc;
    int          cyc;
  } redir_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  trap_recovery_sequencer_if #(.PTR_W(PTR_W)) io ();

  trap_recovery_sequencer #(
    .ROB_DEPTH(DEPTH),
    .PTR_W(PTR_W),
    .DRAIN_CYCLES(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io(io)
  );

  flush_t      flush_q[$];
  redir_t      redir_q[$];
  int          n_vec = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          exp_drops = 0;
  int          seen_drops = 0;
  logic [31:0] exp_epc = '0;
  bit          ready_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: flush indices tail-1 downward for (tail-ptr) mod DEPTH entries, full ROB when equal and full
  task automatic start_seq(input logic [PTR_W-1:0] ptr, input logic [PTR_W-1:0] tail, input bit full,
                           input logic [31:0] tpc, input logic [31:0] epcv);
    int     cnt;
    int     n;
    flush_t f;
    redir_t r;
    @(posedge clk); #1;
    io.recover_rob_ptr = ptr;
    io.rob_tail        = tail;
    io.rob_full        = full;
    io.trap_pc         = tpc;
    io.exception_pc    = epcv;
    io.recover         = 1'b1;
    n   = cyc + 1;
    cnt = (int'(tail) - int'(ptr) + DEPTH) % DEPTH;
    if (cnt == 0 && full) cnt = DEPTH;
    for (int k = 0; k < cnt; k++) begin
      f.idx = PTR_W'((int'(tail) - 1 - k + 2 * DEPTH) % DEPTH);
      f.cyc = n + k;
      flush_q.push_back(f);
    end
    r.pc  = tpc;
    r.exc = epcv;
    r.cyc = n + cnt + D;
    redir_q.push_back(r);
  endtask

  task automatic issue(input logic [PTR_W-1:0] ptr, input logic [PTR_W-1:0] tail, input bit full,
                       input logic [31:0] tpc, input logic [31:0] epcv, input int hold,
                       input bit drop, input bit stall);
    int  w;
    bit  got;
    start_seq(ptr, tail, full, tpc, epcv);
    @(posedge clk); #1;
    io.trap_pc         = $urandom;
    io.exception_pc    = $urandom;
    io.rob_tail        = PTR_W'($urandom);
    io.recover_rob_ptr = PTR_W'($urandom);
    io.rob_full        = 1'($urandom);
    if (drop) begin
      io.recover = 1'b0;
      @(posedge clk); #1;
      io.recover = 1'b1;
      exp_drops++;
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    io.recover = 1'b0;
    if (stall) begin
      got = 1'b0;
      for (w = 0; w < 100 && !got; w++) begin
        if (io.redirect_valid) got = 1'b1;
        else begin
          @(posedge clk); #1;
        end
      end
      if (!got) chk("stall_wait_timeout", 1, 0);
      repeat (3) begin
        @(posedge clk); #1;
      end
      io.redirect_ready = 1'b1;
    end
    got = 1'b0;
    for (w = 0; w < 200 && !got; w++) begin
      @(posedge clk); #1;
      if (!io.busy && redir_q.size() == 0) got = 1'b1;
    end
    if (!got) chk("idle_wait_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  initial begin : ready_gen
    forever begin
      @(posedge clk); #1;
      if (ready_rand) io.redirect_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin : monitor
    flush_t      f;
    redir_t      r;
    bit          in_redir;
    bit          has_r;
    bit          epc_pending;
    logic [31:0] epc_next;
    in_redir    = 1'b0;
    has_r       = 1'b0;
    epc_pending = 1'b0;
    epc_next    = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (epc_pending) begin
          chk("epc_after_accept", io.epc, epc_next);
          epc_pending = 1'b0;
        end
        if (io.recover_dropped) seen_drops++;
        if (io.rob_flush_valid) begin
          if (flush_q.size() == 0) chk("flush_unexpected", 1, 0);
          else begin
            f = flush_q.pop_front();
            chk("flush_idx", io.rob_flush_idx, f.idx);
            chk("flush_cycle", cyc, f.cyc);
          end
        end
        if (io.redirect_valid) begin
          if (!in_redir) begin
            in_redir = 1'b1;
            has_r    = (redir_q.size() != 0);
            if (!has_r) chk("redirect_unexpected", 1, 0);
            else begin
              r = redir_q[0];
              chk("redirect_cycle", cyc, r.cyc);
              chk("redirect_pc", io.redirect_pc, r.pc);
            end
          end else if (has_r) begin
            chk("redirect_pc_hold", io.redirect_pc, r.pc);
          end
          if (io.redirect_ready) begin
            if (has_r) begin
              void'(redir_q.pop_front());
              epc_pending = 1'b1;
              epc_next    = r.exc;
              exp_epc     = r.exc;
            end
            in_redir = 1'b0;
          end else begin
            chk("epc_before_accept", io.epc, exp_epc);
          end
        end
      end else begin
        in_redir    = 1'b0;
        epc_pending = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    io.recover         = 1'b0;
    io.recover_rob_ptr = '0;
    io.trap_pc         = '0;
    io.exception_pc    = '0;
    io.rob_tail        = '0;
    io.rob_full        = 1'b0;
    io.redirect_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flush_valid", io.rob_flush_valid, 0);
    chk("rst_busy", io.busy, 0);
    chk("rst_pipe_flush", io.pipe_flush, 0);
    chk("rst_redirect_valid", io.redirect_valid, 0);
    chk("rst_redirect_pc", io.redirect_pc, 0);
    chk("rst_epc", io.epc, 0);
    chk("rst_dropped", io.recover_dropped, 0);
    reset = 1'b1;

    issue(4'd3, 4'd6, 1'b0, 32'h80, 32'h1C, 1, 1'b0, 1'b0);
    chk("basic_epc", io.epc, 32'h1C);
    issue(4'd14, 4'd1, 1'b0, 32'h100, 32'h2C, 1, 1'b0, 1'b0);
    issue(4'd7, 4'd7, 1'b0, 32'h200, 32'h3C, 1, 1'b0, 1'b0);
    issue(4'd5, 4'd5, 1'b1, 32'h300, 32'h4C, 1, 1'b0, 1'b0);
    issue(4'd2, 4'd9, 1'b0, 32'h400, 32'h5C, 10, 1'b1, 1'b0);
    io.redirect_ready = 1'b0;
    issue(4'd0, 4'd2, 1'b0, 32'h500, 32'h6C, 1, 1'b0, 1'b1);
    chk("stall_epc", io.epc, 32'h6C);

    ready_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue(PTR_W'($urandom), PTR_W'($urandom), ($urandom_range(0, 3) == 0), $urandom, $urandom,
            $urandom_range(1, 6), ($urandom_range(0, 2) == 0), 1'b0);
    end
    ready_rand = 1'b0;
    io.redirect_ready = 1'b1;

    start_seq(4'd2, 4'd10, 1'b0, 32'h600, 32'h7C);
    @(posedge clk); #1;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("abort_flush_valid", io.rob_flush_valid, 0);
    chk("abort_flush_idx", io.rob_flush_idx, 0);
    chk("abort_busy", io.busy, 0);
    chk("abort_pipe_flush", io.pipe_flush, 0);
    chk("abort_redirect_valid", io.redirect_valid, 0);
    chk("abort_redirect_pc", io.redirect_pc, 0);
    chk("abort_epc", io.epc, 0);
    flush_q.delete();
    redir_q.delete();
    exp_epc = '0;
    io.recover = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_abort_busy", io.busy, 0);
    chk("post_abort_epc", io.epc, 0);

    chk("drop_count", seen_drops, exp_drops);
    chk("flush_queue_empty", flush_q.size(), 0);
    chk("redirect_queue_empty", redir_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
